// File: rtl/alarm_pkg.sv
// Shared field positions, FSM encodings and day constants for the alarm trigger path.
package alarm_pkg;

   // Alarm register word layout: [12]=enable, [11:6]=hour, [5:0]=minute
   localparam int WORD_W  = 13;
   localparam int EN_BIT  = 12;
   localparam int HR_MSB  = 11;
   localparam int HR_LSB  = 6;
   localparam int MIN_MSB = 5;
   localparam int MIN_LSB = 0;

   // FSM encodings; the spare code 2'b11 is never entered and falls back to idle
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RING   = 2'b01,
      ST_SNOOZE = 2'b10
   } alarm_state_e;

   // Day numbering of the running clock; 7 marks an invalid day
   localparam logic [2:0] SUN         = 3'd0;
   localparam logic [2:0] MON         = 3'd1;
   localparam logic [2:0] TUE         = 3'd2;
   localparam logic [2:0] WED         = 3'd3;
   localparam logic [2:0] THU         = 3'd4;
   localparam logic [2:0] FRI         = 3'd5;
   localparam logic [2:0] SAT         = 3'd6;
   localparam logic [2:0] DAY_INVALID = 3'd7;

   // True when an alarm word is enabled and its hour/minute equal the given time
   function automatic logic word_matches(input logic [WORD_W-1:0] word,
                                         input logic [5:0]        hour,
                                         input logic [5:0]        minute);
      return word[EN_BIT] &&
             (word[HR_MSB:HR_LSB]   == hour) &&
             (word[MIN_MSB:MIN_LSB] == minute);
   endfunction

endpackage

// File: rtl/alarm_trigger_unit_day_match.sv
// Picks today's alarm word and compares it against the running time.
// Pure combinational; the result is only meaningful in the Min_Tick cycle.
module alarm_trigger_unit_day_match
   import alarm_pkg::*;
(
   input  logic [WORD_W-1:0] q_r0,
   input  logic [WORD_W-1:0] q_r1,
   input  logic [WORD_W-1:0] q_r2,
   input  logic [WORD_W-1:0] q_r3,
   input  logic [WORD_W-1:0] q_r4,
   input  logic [WORD_W-1:0] q_r5,
   input  logic [WORD_W-1:0] q_r6,
   input  logic [2:0]        cur_day,
   input  logic [5:0]        cur_hour,
   input  logic [5:0]        cur_min,
   input  logic              min_tick,
   output logic              hit
);

   logic [WORD_W-1:0] sel;

   // 7:1 day mux; an invalid day selects an all-zero (disabled) word
   always_comb begin
      sel = '0;
      case (cur_day)
         SUN:     sel = q_r0;
         MON:     sel = q_r1;
         TUE:     sel = q_r2;
         WED:     sel = q_r3;
         THU:     sel = q_r4;
         FRI:     sel = q_r5;
         SAT:     sel = q_r6;
         default: sel = '0;
      endcase
   end

   assign hit = min_tick && (cur_day != DAY_INVALID) &&
                word_matches(sel, cur_hour, cur_min);

endmodule

// File: rtl/alarm_trigger_unit.sv
// Alarm trigger: starts ringing on a minute-boundary match, then runs the
// ring / snooze / auto-off sequence driven by one-cycle control pulses.
// All control inputs (Min_Tick, Sec_Tick, Snooze, Stop) are single-cycle
// pulses with no handshake; a pulse is consumed in the cycle it is high.
module alarm_trigger_unit
   import alarm_pkg::*;
#(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3,
   parameter int CNT_W      = 9
)(
   input  logic              Clk,
   input  logic              Clr,
   input  logic [WORD_W-1:0] Q_r0,
   input  logic [WORD_W-1:0] Q_r1,
   input  logic [WORD_W-1:0] Q_r2,
   input  logic [WORD_W-1:0] Q_r3,
   input  logic [WORD_W-1:0] Q_r4,
   input  logic [WORD_W-1:0] Q_r5,
   input  logic [WORD_W-1:0] Q_r6,
   input  logic [2:0]        Cur_Day,
   input  logic [5:0]        Cur_Hour,
   input  logic [5:0]        Cur_Min,
   input  logic              Min_Tick,
   input  logic              Sec_Tick,
   input  logic              Snooze,
   input  logic              Stop,
   output logic              Alarm,
   output logic              Snoozing,
   output logic [1:0]        Snooze_Cnt,
   output logic [1:0]        dbg_state
);

   localparam logic [CNT_W-1:0] RING_TERM   = CNT_W'(RING_SEC);
   localparam logic [CNT_W-1:0] SNOOZE_TERM = CNT_W'(SNOOZE_SEC);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_SAT     = '1;
   localparam logic [1:0]       SNZ_MAX     = 2'(MAX_SNOOZE);

   alarm_state_e     state, state_next;
   logic [CNT_W-1:0] sec_cnt, sec_cnt_next, sec_cnt_inc;
   logic [1:0]       snz_cnt, snz_cnt_next;
   logic             hit;

   alarm_trigger_unit_day_match u_day_match (
      .q_r0     (Q_r0),
      .q_r1     (Q_r1),
      .q_r2     (Q_r2),
      .q_r3     (Q_r3),
      .q_r4     (Q_r4),
      .q_r5     (Q_r5),
      .q_r6     (Q_r6),
      .cur_day  (Cur_Day),
      .cur_hour (Cur_Hour),
      .cur_min  (Cur_Min),
      .min_tick (Min_Tick),
      .hit      (hit)
   );

   // Saturating increment so the second counter can never wrap
   assign sec_cnt_inc = (sec_cnt == CNT_SAT) ? sec_cnt : sec_cnt + CNT_ONE;

   // Next-state logic; priority is Stop > Snooze > counter expiry > Hit
   always_comb begin
      state_next   = state;
      sec_cnt_next = sec_cnt;
      snz_cnt_next = snz_cnt;
      case (state)
         ST_IDLE: begin
            // Only a match starts an event; any pulse in the same cycle is dropped
            if (hit) begin
               state_next   = ST_RING;
               sec_cnt_next = '0;
               snz_cnt_next = '0;
            end
         end
         ST_RING: begin
            if (Stop) begin
               state_next = ST_IDLE;
            end else if (Snooze) begin
               if (snz_cnt < SNZ_MAX) begin
                  state_next   = ST_SNOOZE;
                  snz_cnt_next = snz_cnt + 2'd1;
                  sec_cnt_next = '0;
               end else begin
                  // Snooze budget exhausted: behaves as Stop
                  state_next = ST_IDLE;
               end
            end else if (Sec_Tick) begin
               sec_cnt_next = sec_cnt_inc;
               if (sec_cnt_inc >= RING_TERM) begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_SNOOZE: begin
            // Further snooze presses are ignored while already snoozing
            if (Stop) begin
               state_next = ST_IDLE;
            end else if (Sec_Tick) begin
               if (sec_cnt_inc >= SNOOZE_TERM) begin
                  state_next   = ST_RING;
                  sec_cnt_next = '0;
               end else begin
                  sec_cnt_next = sec_cnt_inc;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs; Clr drops everything at once
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state    <= ST_IDLE;
         sec_cnt  <= '0;
         snz_cnt  <= '0;
         Alarm    <= 1'b0;
         Snoozing <= 1'b0;
      end else begin
         state    <= state_next;
         sec_cnt  <= sec_cnt_next;
         snz_cnt  <= snz_cnt_next;
         Alarm    <= (state_next == ST_RING);
         Snoozing <= (state_next == ST_SNOOZE);
      end
   end

   assign Snooze_Cnt = snz_cnt;
   assign dbg_state  = state;

endmodule

// File: tb/tb_alarm_trigger_unit.sv
// Self-checking bench for alarm_trigger_unit: directed scenarios followed by
// randomized traffic, all compared against an event-level reference model.
module tb_alarm_trigger_unit;

   localparam int RING_SEC   = 60;
   localparam int SNOOZE_SEC = 300;
   localparam int MAX_SNOOZE = 3;

   logic        clk;
   logic        clr;
   logic [12:0] q_r [7];
   logic [2:0]  cur_day;
   logic [5:0]  cur_hour;
   logic [5:0]  cur_min;
   logic        min_tick;
   logic        sec_tick;
   logic        snooze;
   logic        stop;
   logic        alarm;
   logic        snoozing;
   logic [1:0]  snooze_cnt;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard entry: {state[1:0], alarm, snoozing, snooze_cnt[1:0]}
   logic [5:0] exp_q[$];

   // Reference model: event view (ringing/snoozing flags, seconds left, snoozes used)
   bit m_ring;
   bit m_snz;
   int m_left;
   int m_used;

   alarm_trigger_unit #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_SEC (SNOOZE_SEC),
      .MAX_SNOOZE (MAX_SNOOZE),
      .CNT_W      (9)
   ) dut (
      .Clk        (clk),
      .Clr        (clr),
      .Q_r0       (q_r[0]),
      .Q_r1       (q_r[1]),
      .Q_r2       (q_r[2]),
      .Q_r3       (q_r[3]),
      .Q_r4       (q_r[4]),
      .Q_r5       (q_r[5]),
      .Q_r6       (q_r[6]),
      .Cur_Day    (cur_day),
      .Cur_Hour   (cur_hour),
      .Cur_Min    (cur_min),
      .Min_Tick   (min_tick),
      .Sec_Tick   (sec_tick),
      .Snooze     (snooze),
      .Stop       (stop),
      .Alarm      (alarm),
      .Snoozing   (snoozing),
      .Snooze_Cnt (snooze_cnt),
      .dbg_state  (dbg_state)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      n_errors++;
      $display("FAIL watchdog observed timeout required finish");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [12:0] mk_word(input bit en, input int hour, input int minute);
      logic [12:0] w;
      w = {en, 6'(hour), 6'(minute)};
      return w;
   endfunction

   function automatic bit model_hit();
      logic [12:0] w;
      if (!min_tick || cur_day == 3'd7) return 1'b0;
      w = q_r[cur_day];
      return w[12] && (int'(w[11:6]) == int'(cur_hour)) && (int'(w[5:0]) == int'(cur_min));
   endfunction

   task automatic model_reset();
      m_ring = 0;
      m_snz  = 0;
      m_left = 0;
      m_used = 0;
   endtask

   // Advance the model by one clock using the inputs currently applied
   task automatic model_step();
      if (!m_ring && !m_snz) begin
         if (model_hit()) begin
            m_ring = 1;
            m_left = RING_SEC;
            m_used = 0;
         end
      end else if (stop) begin
         m_ring = 0;
         m_snz  = 0;
      end else if (m_ring) begin
         if (snooze) begin
            m_ring = 0;
            if (m_used < MAX_SNOOZE) begin
               m_snz  = 1;
               m_used = m_used + 1;
               m_left = SNOOZE_SEC;
            end
         end else if (sec_tick) begin
            m_left = m_left - 1;
            if (m_left == 0) m_ring = 0;
         end
      end else begin
         if (sec_tick) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_snz  = 0;
               m_ring = 1;
               m_left = RING_SEC;
            end
         end
      end
   endtask

   function automatic logic [5:0] model_pack();
      logic [1:0] st;
      st = m_ring ? 2'b01 : (m_snz ? 2'b10 : 2'b00);
      return {st, 1'(m_ring), 1'(m_snz), 2'(m_used)};
   endfunction

   task automatic compare_outputs(input string tag);
      logic [5:0] e;
      if (exp_q.size() == 0) begin
         check_val({tag, "_queue"}, 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check_val({tag, "_alarm"},  {31'd0, alarm},      {31'd0, e[3]});
      check_val({tag, "_snz"},    {31'd0, snoozing},   {31'd0, e[2]});
      check_val({tag, "_cnt"},    {30'd0, snooze_cnt}, {30'd0, e[1:0]});
      check_val({tag, "_state"},  {30'd0, dbg_state},  {30'd0, e[5:4]});
   endtask

   task automatic clear_pulses();
      min_tick = 1'b0;
      sec_tick = 1'b0;
      snooze   = 1'b0;
      stop     = 1'b0;
   endtask

   // One clock: called just after a falling edge with inputs applied
   task automatic tick(input string tag);
      model_step();
      exp_q.push_back(model_pack());
      @(posedge clk);
      #1;
      compare_outputs(tag);
      @(negedge clk);
      clear_pulses();
   endtask

   task automatic set_time(input int day, input int hour, input int minute);
      cur_day  = 3'(day);
      cur_hour = 6'(hour);
      cur_min  = 6'(minute);
   endtask

   task automatic fire_minute(input string tag);
      min_tick = 1'b1;
      sec_tick = 1'b1;
      tick(tag);
   endtask

   task automatic secs(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         sec_tick = 1'b1;
         tick(tag);
      end
   endtask

   task automatic press_snooze(input string tag);
      snooze = 1'b1;
      tick(tag);
   endtask

   initial begin
      clr = 1'b1;
      for (int d = 0; d < 7; d++) q_r[d] = '0;
      set_time(0, 0, 0);
      clear_pulses();
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_alarm", {31'd0, alarm},      32'd0);
      check_val("rst_snz",   {31'd0, snoozing},   32'd0);
      check_val("rst_cnt",   {30'd0, snooze_cnt}, 32'd0);
      check_val("rst_state", {30'd0, dbg_state},  32'd0);
      clr = 1'b0;
      tick("idle");

      // Non-matching cases: disabled word, wrong day, invalid day
      q_r[2] = mk_word(0, 7, 30);
      q_r[3] = mk_word(0, 0, 0);
      set_time(2, 7, 30);
      fire_minute("t2_dis");
      check_val("t2_dis_alarm", {31'd0, alarm}, 32'd0);
      q_r[2] = mk_word(1, 7, 30);
      set_time(3, 7, 30);
      fire_minute("t2_day3");
      check_val("t2_day3_alarm", {31'd0, alarm}, 32'd0);
      set_time(7, 7, 30);
      fire_minute("t2_day7");
      check_val("t2_day7_alarm", {31'd0, alarm}, 32'd0);
      set_time(2, 7, 31);
      fire_minute("t2_min");
      check_val("t2_min_alarm", {31'd0, alarm}, 32'd0);

      // Basic trigger and auto-off after RING_SEC seconds
      set_time(2, 7, 30);
      fire_minute("t1_hit");
      check_val("t1_alarm", {31'd0, alarm},    32'd1);
      check_val("t1_snz",   {31'd0, snoozing}, 32'd0);
      secs(RING_SEC - 1, "t3_ring");
      check_val("t3_before_alarm", {31'd0, alarm}, 32'd1);
      secs(1, "t3_last");
      check_val("t3_off_alarm", {31'd0, alarm},     32'd0);
      check_val("t3_off_state", {30'd0, dbg_state}, 32'd0);

      // Snooze cycle three times, fourth press stops
      fire_minute("t4_hit");
      for (int s = 1; s <= MAX_SNOOZE; s++) begin
         press_snooze("t4_snz");
         check_val("t4_snz_alarm", {31'd0, alarm},      32'd0);
         check_val("t4_snz_flag",  {31'd0, snoozing},   32'd1);
         check_val("t4_snz_cnt",   {30'd0, snooze_cnt}, 32'(s));
         secs(SNOOZE_SEC - 1, "t4_wait");
         check_val("t4_wait_alarm", {31'd0, alarm}, 32'd0);
         secs(1, "t4_rering");
         check_val("t4_rering_alarm", {31'd0, alarm}, 32'd1);
      end
      press_snooze("t4_fourth");
      check_val("t4_fourth_alarm", {31'd0, alarm},      32'd0);
      check_val("t4_fourth_snz",   {31'd0, snoozing},   32'd0);
      check_val("t4_fourth_cnt",   {30'd0, snooze_cnt}, 32'd3);

      // Stop and Snooze together while ringing
      fire_minute("t5_hit");
      check_val("t5_hit_cnt", {30'd0, snooze_cnt}, 32'd0);
      press_snooze("t5_snz");
      secs(SNOOZE_SEC, "t5_wait");
      stop   = 1'b1;
      snooze = 1'b1;
      tick("t5_both");
      check_val("t5_both_alarm", {31'd0, alarm},      32'd0);
      check_val("t5_both_snz",   {31'd0, snoozing},   32'd0);
      check_val("t5_both_cnt",   {30'd0, snooze_cnt}, 32'd1);

      // Asynchronous clear in the middle of a snooze
      fire_minute("t6_hit");
      press_snooze("t6_snz");
      secs(10, "t6_wait");
      #2;
      clr = 1'b1;
      #1;
      model_reset();
      check_val("t6_clr_alarm", {31'd0, alarm},      32'd0);
      check_val("t6_clr_snz",   {31'd0, snoozing},   32'd0);
      check_val("t6_clr_cnt",   {30'd0, snooze_cnt}, 32'd0);
      @(negedge clk);
      clr = 1'b0;
      tick("t6_idle");
      fire_minute("t6_rehit");
      check_val("t6_rehit_alarm", {31'd0, alarm},      32'd1);
      check_val("t6_rehit_cnt",   {30'd0, snooze_cnt}, 32'd0);

      // Randomized traffic against the reference model
      for (int d = 0; d < 7; d++)
         q_r[d] = mk_word($urandom_range(0, 3) != 0, $urandom_range(0, 23), $urandom_range(0, 59));
      for (int c = 0; c < 5000; c++) begin
         if ($urandom_range(0, 199) == 0)
            q_r[$urandom_range(0, 6)] = mk_word($urandom_range(0, 1), $urandom_range(0, 23),
                                                $urandom_range(0, 59));
         if ($urandom_range(0, 19) == 0) begin
            int d;
            d = $urandom_range(0, 7);
            if (d < 7 && $urandom_range(0, 1) == 1)
               set_time(d, int'(q_r[d][11:6]), int'(q_r[d][5:0]));
            else
               set_time(d, $urandom_range(0, 23), $urandom_range(0, 59));
            min_tick = 1'b1;
            sec_tick = 1'b1;
         end else begin
            sec_tick = ($urandom_range(0, 1) == 1);
         end
         snooze = ($urandom_range(0, 29) == 0);
         stop   = ($urandom_range(0, 79) == 0);
         tick("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
